// File: rtl/fxp_pkg.sv
// Shared Q6.10 constants, divider state encoding and a magnitude helper used by the fixed-point blocks.
package fxp_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  // DATA_W+1 bits so the magnitude of the most negative value is exact.
  function automatic logic [DATA_W:0] abs_mag(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    return ext[DATA_W] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/fxp_seq_divider_if.sv
// Request/result handshake bundle for the sequential Q6.10 divider.
interface fxp_seq_divider_if;
  import fxp_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_dividend;
  logic [DATA_W-1:0] i_divisor;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_quotient;
  logic              o_div_by_zero;

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_div_by_zero
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_div_by_zero
  );

endinterface

// File: rtl/fxp_seq_divider.sv
// Radix-2 restoring signed Q6.10 divider, one request in flight; result after ITERS+1 cycles (ITERS+2 with
// `DIV_ROUND_EN, 1 cycle for zero divisor) and held stable until the consumer takes it.
module fxp_seq_divider
  import fxp_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  fxp_seq_divider_if.slave   bus
);

  localparam int ITERS = DATA_W + FRAC_W;
`ifdef DIV_ROUND_EN
  localparam int NBITS = ITERS + 1;
`else
  localparam int NBITS = ITERS;
`endif
  localparam int MAG_W  = DATA_W + 1;
  localparam int NUM_SH = NBITS - ITERS + FRAC_W;
  localparam int CNT_W  = $clog2(NBITS);

  div_state_e        state_q, state_d;
  logic [NBITS-1:0]  num_q, num_d;
  logic [NBITS-1:0]  quo_q, quo_d;
  logic [MAG_W-1:0]  rem_q, rem_d;
  logic [MAG_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic              dbz_q, dbz_d;

  logic [MAG_W:0]    rem_sh;
  logic [MAG_W:0]    trial;
  logic [NBITS-1:0]  res_mag;
  logic [DATA_W-1:0] mag_clip;
  logic [DATA_W-1:0] calc_q;

  assign rem_sh = {rem_q, num_q[NBITS-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

`ifdef DIV_ROUND_EN
  // Guard bit added to the truncated magnitude rounds half away from zero.
  assign res_mag = {1'b0, quo_q[NBITS-1:1]} + {{(NBITS-1){1'b0}}, quo_q[0]};
`else
  assign res_mag = quo_q;
`endif

  assign mag_clip = (res_mag > NBITS'(SAT_POS)) ? SAT_POS : res_mag[DATA_W-1:0];
  assign calc_q   = neg_q ? (~mag_clip + 1'b1) : mag_clip;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    vld_d   = vld_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          neg_d   = bus.i_dividend[DATA_W-1] ^ bus.i_divisor[DATA_W-1];
          dvs_d   = abs_mag(bus.i_divisor);
          num_d   = NBITS'(abs_mag(bus.i_dividend)) << NUM_SH;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          zero_d  = (bus.i_divisor == '0);
          state_d = (bus.i_divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        rem_d = trial[MAG_W] ? rem_sh[MAG_W-1:0] : trial[MAG_W-1:0];
        quo_d = {quo_q[NBITS-2:0], ~trial[MAG_W]};
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NBITS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is registered on the first DONE cycle, then held until taken.
        if (!vld_q) begin
          vld_d  = 1'b1;
          quot_d = zero_q ? (neg_q ? SAT_NEG : SAT_POS) : calc_q;
          dbz_d  = zero_q;
        end else if (bus.i_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.o_ready       = (state_q == IDLE);
  assign bus.o_valid       = vld_q;
  assign bus.o_quotient    = quot_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Scoreboard bench for fxp_seq_divider: directed Q6.10 vectors, hold/backpressure and reset-abort cases.
module tb_fxp_seq_divider;

`ifdef DIV_ROUND_EN
  localparam int LAT = 28;
  localparam logic [15:0] Q_2_3  = 16'h02AB;
  localparam logic [15:0] Q_N2_3 = 16'hFD55;
`else
  localparam int LAT = 27;
  localparam logic [15:0] Q_2_3  = 16'h02AA;
  localparam logic [15:0] Q_N2_3 = 16'hFD56;
`endif

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t cur;
  logic prev_vld;

  fxp_seq_divider_if bus();

  fxp_seq_divider dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // Monitor: pops on each new result, then checks the held value every cycle it stays valid.
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.o_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%0h exp=none", bus.o_quotient);
        end else begin
          cur = sb.pop_front();
          chk("quotient", int'(bus.o_quotient), int'(cur.q));
          chk("div_by_zero", int'(bus.o_div_by_zero), int'(cur.dbz));
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end else if (bus.o_valid && prev_vld) begin
        chk("hold_quotient", int'(bus.o_quotient), int'(cur.q));
        chk("hold_dbz", int'(bus.o_div_by_zero), int'(cur.dbz));
      end
      prev_vld = bus.o_valid;
    end
  end

  // Called right after a negedge; returns #1 after the accepting posedge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                      input logic dbz, input int lat, input bit expect_it, output int acc);
    exp_t e;
    int   n;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    bus.i_valid    = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=busy exp=ready");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.i_valid = 1'b0;
    if (expect_it) begin
      e.q   = q;
      e.dbz = dbz;
      e.lat = lat;
      e.acc = acc;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  vec_t vecs[13] = '{
    '{16'h0C00, 16'h0800, 16'h0600, 1'b0, LAT},
    '{16'hFC00, 16'h1000, 16'hFF00, 1'b0, LAT},
    '{16'h0400, 16'hF000, 16'hFF00, 1'b0, LAT},
    '{16'h0800, 16'h0C00, Q_2_3,    1'b0, LAT},
    '{16'hF800, 16'h0C00, Q_N2_3,   1'b0, LAT},
    '{16'h0400, 16'h0C00, 16'h0155, 1'b0, LAT},
    '{16'h0400, 16'h0000, 16'h7FFF, 1'b1, 1},
    '{16'hFC00, 16'h0000, 16'h8001, 1'b1, 1},
    '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1},
    '{16'h0000, 16'h0400, 16'h0000, 1'b0, LAT},
    '{16'h7C00, 16'h0001, 16'h7FFF, 1'b0, LAT},
    '{16'h8000, 16'h0001, 16'h8001, 1'b0, LAT},
    '{16'h8000, 16'h0400, 16'h8001, 1'b0, LAT}
  };

  initial begin
    int acc;
    int h;
    int n;
    checks = 0;
    errors = 0;
    cyc = 0;
    prev_vld = 1'b0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_ready", int'(bus.o_ready), 1);
    chk("rst_o_valid", int'(bus.o_valid), 0);
    chk("rst_o_quotient", int'(bus.o_quotient), 0);
    chk("rst_o_div_by_zero", int'(bus.o_div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].lat, 1'b1, acc);
    end

    // Backpressure: result held, busy, competing request ignored.
    n = 0;
    while (!(bus.o_ready && !bus.o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.i_ready = 1'b0;
    send(16'h0C00, 16'h0800, 16'h0600, 1'b0, LAT, 1'b1, acc);
    n = 0;
    while (!bus.o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", int'(bus.o_valid), 1);
    bus.i_dividend = 16'h0400;
    bus.i_divisor  = 16'h0400;
    bus.i_valid    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_o_ready", int'(bus.o_ready), 0);
      chk("hold_o_valid", int'(bus.o_valid), 1);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    h = cyc;
    @(negedge clk);
    chk("post_hs_o_valid", int'(bus.o_valid), 0);
    chk("post_hs_o_ready", int'(bus.o_ready), 1);
    send(16'h0400, 16'h0400, 16'h0400, 1'b0, LAT, 1'b1, acc);
    chk("accept_after_hs", acc - h, 1);

    // Reset mid-calculation: nothing from the aborted divide may appear.
    n = 0;
    while (!(bus.o_ready && !bus.o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    send(16'h0C00, 16'h0400, 16'h0C00, 1'b0, LAT, 1'b0, acc);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_o_ready", int'(bus.o_ready), 1);
    chk("abort_o_valid", int'(bus.o_valid), 0);
    repeat (40) @(negedge clk);
    chk("abort_no_result", int'(bus.o_valid), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
